// File: rtl/mole_mod_counter.sv
// Modulo-N up/down counter: the timing/position sequencer for mole selection and
// round timers. It has enable, synchronous clear, parallel load with a saturating
// clamp, a combinational terminal-count flag and a registered wrap pulse.
// Optional prescaler: define MOLE_CNT_PRESCALE_EN to step once every PRESCALE
// enabled cycles. When the macro is undefined, every enabled cycle is a step.
module mole_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Extended width so that MODULUS == 2**WIDTH is representable.
  localparam int unsigned Cw = WIDTH + 1;
  localparam logic [Cw-1:0]    ModExt   = Cw'(MODULUS);
  localparam logic [Cw-1:0]    MaxExt   = Cw'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetCnt = WIDTH'(RESET_VAL);

  // Reject illegal parameterisations at elaboration time.
  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("mole_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("mole_mod_counter: RESET_VAL must be below MODULUS");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mole_mod_counter: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [Cw-1:0]    cnt_ext;
  logic [Cw-1:0]    load_ext;
  logic             step;

`ifdef MOLE_CNT_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  assign step = en && (ps_q == PsLast);

  // Prescaler next state: clear/load discard progress, en=0 holds it.
  always_comb begin
    ps_d = ps_q;
    if (clear || load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = step ? '0 : ps_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step = en;
`endif

  assign cnt_ext  = {1'b0, count_q};
  assign load_ext = {1'b0, load_val};

  // Terminal count depends on the live direction, not the previous step's.
  assign tc = up_dn ? (cnt_ext == MaxExt) : (count_q == '0);

  // Next count and wrap, in priority order clear > load > step > hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = ResetCnt;
    end else if (load) begin
      count_d = (load_ext < ModExt) ? load_val : WIDTH'(MaxExt);
    end else if (step) begin
      wrap_d = tc;
      if (up_dn) begin
        count_d = (cnt_ext == MaxExt) ? '0 : WIDTH'(cnt_ext + 1'b1);
      end else begin
        count_d = (count_q == '0) ? WIDTH'(MaxExt) : WIDTH'(cnt_ext - 1'b1);
      end
    end
  end

  // Count and wrap registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= ResetCnt;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mole_mod_counter.sv
// Self-checking bench for mole_mod_counter: a default instance driven from a
// vector table, plus MODULUS=10 and PRESCALE=3 instances checked by short
// hand-written sequences.
module tb_mole_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, clear, load;
  logic [3:0] load_val;

  logic [3:0] count16, count10, count_ps;
  logic       tc16, tc10, tc_ps;
  logic       wrap16, wrap10, wrap_ps;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mole_mod_counter dut16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(count16), .tc(tc16), .wrap(wrap16)
  );

  mole_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .PRESCALE(1)) dut10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(count10), .tc(tc10), .wrap(wrap10)
  );

  mole_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0), .PRESCALE(3)) dut_ps (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(count_ps), .tc(tc_ps), .wrap(wrap_ps)
  );

  typedef struct {
    logic       rst, en, up, clr, ld;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       tc, wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic e, input logic up, input logic clr,
                              input logic ld, input logic [3:0] lv, input logic [3:0] cnt,
                              input logic t, input logic w);
    vec_t v;
    v.rst = rst; v.en = e; v.up = up; v.clr = clr; v.ld = ld; v.lv = lv;
    v.cnt = cnt; v.tc = t; v.wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic e, input logic up, input logic clr,
                       input logic ld, input logic [3:0] lv);
    reset = rst; en = e; up_dn = up; clear = clr; load = ld; load_val = lv;
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [3:0] exp_cnt;
    logic [3:0] dn_cnt[5];
    logic       dn_tc[5];
    logic       dn_wrap[5];

    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Default instance vector table.
    add(1, 0, 1, 0, 0, 0,  0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      add(0, 1, 1, 0, 0, 0, 4'(k % 16), (k % 16) == 15, k == 16);
    end
    add(0, 1, 1, 0, 1, 7,  7, 0, 0);   // load wins over en
    add(0, 1, 1, 0, 0, 0,  8, 0, 0);
    add(0, 0, 1, 0, 0, 0,  8, 0, 0);   // hold
    add(0, 0, 1, 0, 1, 14, 14, 0, 0);
    add(0, 1, 1, 0, 0, 0,  15, 1, 0);
    add(0, 0, 0, 0, 0, 0,  15, 0, 0);  // flip direction at 15: tc drops
    add(0, 1, 0, 0, 0, 0,  14, 0, 0);
    add(0, 1, 0, 0, 0, 0,  13, 0, 0);
    add(0, 1, 0, 0, 0, 0,  12, 0, 0);
    add(0, 0, 0, 0, 1, 1,  1, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  15, 0, 1);  // down wrap
    add(0, 1, 1, 0, 0, 0,  0, 0, 1);   // immediate up wrap: consecutive pulses
    add(0, 0, 1, 0, 1, 5,  5, 0, 0);
    add(0, 1, 1, 1, 1, 3,  0, 0, 0);   // clear beats load and en
    add(0, 1, 1, 0, 0, 0,  1, 0, 0);
    add(1, 1, 1, 1, 0, 0,  0, 0, 0);   // reset with clear
    add(0, 0, 1, 0, 1, 15, 15, 1, 0);
    add(1, 1, 1, 0, 0, 0,  0, 0, 0);   // reset suppresses wrap
    add(0, 1, 1, 0, 0, 0,  1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].ld, vecs[i].lv);
      tick();
      check($sformatf("v%0d count", i), 32'(count16), 32'(vecs[i].cnt));
      check($sformatf("v%0d tc", i), 32'(tc16), 32'(vecs[i].tc));
      check($sformatf("v%0d wrap", i), 32'(wrap16), 32'(vecs[i].wrap));
    end

    // MODULUS=10 counting down through the wrap.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check("m10 reset count", 32'(count10), 32'd0);
    drive(0, 0, 0, 0, 1, 3);
    tick();
    check("m10 load count", 32'(count10), 32'd3);
    check("m10 load tc", 32'(tc10), 32'd0);
    dn_cnt  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    dn_tc   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    dn_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("m10 dn%0d count", i), 32'(count10), 32'(dn_cnt[i]));
      check($sformatf("m10 dn%0d tc", i), 32'(tc10), 32'(dn_tc[i]));
      check($sformatf("m10 dn%0d wrap", i), 32'(wrap10), 32'(dn_wrap[i]));
    end
    drive(0, 0, 0, 0, 1, 12);
    tick();
    check("m10 clamp count", 32'(count10), 32'd9);
    check("m10 clamp wrap", 32'(wrap10), 32'd0);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    check("m10 tc at 9 up", 32'(tc10), 32'd1);
    drive(0, 1, 1, 0, 0, 0);
    tick();
    check("m10 up wrap count", 32'(count10), 32'd0);
    check("m10 up wrap pulse", 32'(wrap10), 32'd1);

    // PRESCALE=3 with a two-cycle en gap after the fourth enabled cycle.
    drive(1, 0, 1, 0, 0, 0);
    tick();
    check("ps reset count", 32'(count_ps), 32'd0);
    n = 0;
    for (int i = 0; i < 11; i++) begin
      drive(0, (i != 4) && (i != 5), 1, 0, 0, 0);
      tick();
      if (en) n++;
`ifdef MOLE_CNT_PRESCALE_EN
      exp_cnt = 4'(n / 3);
`else
      exp_cnt = 4'(n);
`endif
      check($sformatf("ps c%0d count", i), 32'(count_ps), 32'(exp_cnt));
      check($sformatf("ps c%0d wrap", i), 32'(wrap_ps), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
